// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM states, Booth digit selects, default multiply width.
// Pure declarations, no latency and no flow control.
package alu_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Booth digit selects, packed as {zero, two, neg}
  localparam logic [2:0] ZERO = 3'b100;
  localparam logic [2:0] POS1 = 3'b000;
  localparam logic [2:0] POS2 = 3'b010;
  localparam logic [2:0] NEG1 = 3'b001;
  localparam logic [2:0] NEG2 = 3'b011;

  function automatic logic [2:0] booth_digit(input logic [2:0] bits);
    logic [2:0] sel;
    case (bits)
      3'b001, 3'b010: sel = POS1;
      3'b011:         sel = POS2;
      3'b100:         sel = NEG2;
      3'b101, 3'b110: sel = NEG1;
      default:        sel = ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_pair_recoder.sv
// Radix-4 Booth recoder: three overlapping multiplier bits -> {zero, two, neg} digit selects.
// Combinational, zero latency; no flow control.
module booth_pair_recoder
  import alu_pkg::*;
(
  input  logic [2:0] bits,
  output logic       zero,
  output logic       two,
  output logic       neg
);

  assign {zero, two, neg} = booth_digit(bits);

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, one digit pair per clock; optional unsigned mode via MUL_UNSIGNED_EN.
// Latency WIDTH/2 edges from accept to done (WIDTH/2+1 for unsigned); start ignored while busy.
module booth_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
`ifdef MUL_UNSIGNED_EN
  input  logic                 is_unsigned,
`endif
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // Unsigned operands need one extra accumulator bit and a zero-extended multiplier digit.
`ifdef MUL_UNSIGNED_EN
  localparam int AW = WIDTH + 3;
  localparam int QW = WIDTH + 2;
`else
  localparam int AW = WIDTH + 2;
  localparam int QW = WIDTH;
`endif
  localparam int PW = AW + QW + 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_S = CW'(WIDTH / 2 - 1);

  mul_state_e         state;
  logic [AW-1:0]      m_reg;
  logic [PW-1:0]      p_reg;
  logic [CW-1:0]      count;
  logic [CW-1:0]      last;

  logic               zero, two, neg;
  logic [AW-1:0]      m_sel, addend, acc_sum;
  logic [PW-1:0]      p_nxt;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [AW-1:0]      m_ext;
  logic [QW-1:0]      q_ext;
  logic [CW-1:0]      last_ext;

`ifdef MUL_UNSIGNED_EN
  logic uns_reg;
  logic sx;

  assign sx       = ~is_unsigned;
  assign m_ext    = {{3{sx & multiplicand[WIDTH-1]}}, multiplicand};
  assign q_ext    = {{2{sx & multiplier[WIDTH-1]}}, multiplier};
  assign last_ext = is_unsigned ? CW'(WIDTH / 2) : LAST_S;
  // Signed ops stop one digit early, leaving the product two bits higher in P.
  assign prod_nxt = uns_reg ? p_nxt[2*WIDTH:1] : p_nxt[2*WIDTH+2:3];
`else
  assign m_ext    = {{2{multiplicand[WIDTH-1]}}, multiplicand};
  assign q_ext    = multiplier;
  assign last_ext = LAST_S;
  assign prod_nxt = p_nxt[2*WIDTH:1];
`endif

  booth_pair_recoder u_recoder (
    .bits (p_reg[2:0]),
    .zero (zero),
    .two  (two),
    .neg  (neg)
  );

  always_comb begin
    m_sel  = two ? {m_reg[AW-2:0], 1'b0} : m_reg;
    addend = '0;
    if (!zero) addend = neg ? (~m_sel + AW'(1)) : m_sel;
    acc_sum = p_reg[PW-1 -: AW] + addend;
    p_nxt   = PW'($signed({acc_sum, p_reg[PW-AW-1:0]}) >>> 2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      m_reg   <= '0;
      p_reg   <= '0;
      count   <= '0;
      last    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
`ifdef MUL_UNSIGNED_EN
      uns_reg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            m_reg <= m_ext;
            p_reg <= {{AW{1'b0}}, q_ext, 1'b0};
            count <= '0;
            last  <= last_ext;
            busy  <= 1'b1;
            state <= CALC;
`ifdef MUL_UNSIGNED_EN
            uns_reg <= is_unsigned;
`endif
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          p_reg <= p_nxt;
          count <= count + CW'(1);
          if (count == last) begin
            product <= prod_nxt;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
